// File: rtl/countdown_timer_if.sv
// Signal bundle between the key logic (master) and the countdown timer (slave).
// load is a one-cycle strobe with no ready: the timer always accepts it on the cycle it is high.
interface countdown_timer_if;
  logic       run;
  logic       load;
  logic [5:0] preset_hour;
  logic [5:0] preset_minute;
  logic [5:0] preset_second;
  logic [6:0] preset_m_sec;
  logic [5:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [6:0] m_sec;
  logic       running;
  logic       done;
  logic       expire_pulse;
  logic [1:0] state_dbg;

  modport master (
    output run, load, preset_hour, preset_minute, preset_second, preset_m_sec,
    input  hour, minute, second, m_sec, running, done, expire_pulse, state_dbg
  );

  modport slave (
    input  run, load, preset_hour, preset_minute, preset_second, preset_m_sec,
    output hour, minute, second, m_sec, running, done, expire_pulse, state_dbg
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable h:m:s.hundredths countdown timer; steps down once per prescaler tick
// while running and flags expiry when the time reaches zero.
module countdown_timer #(
  parameter int CLOCK_HZ = 50000000,
  parameter int TICK_HZ  = 100
) (
  input  logic              clock,
  input  logic              reset_n,
  countdown_timer_if.slave  tif
);

  // DIV must be at least 2 for the prescaler to make sense.
  localparam int DIV = CLOCK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    hour_q, hour_d;
  logic [5:0]    minute_q, minute_d;
  logic [5:0]    second_q, second_d;
  logic [6:0]    m_sec_q, m_sec_d;
  logic          pulse_q, pulse_d;

  logic [5:0]    dec_hour, dec_minute, dec_second;
  logic [6:0]    dec_m_sec;
  logic [5:0]    cl_hour, cl_minute, cl_second;
  logic [6:0]    cl_m_sec;
  logic          tick;
  logic          time_zero;
  logic          dec_zero;

  assign tick = (state_q == RUN) && (presc_q == PRESC_MAX);

  assign time_zero = (hour_q == 6'd0) && (minute_q == 6'd0) &&
                     (second_q == 6'd0) && (m_sec_q == 7'd0);

  assign cl_hour   = (tif.preset_hour   > 6'd23) ? 6'd23 : tif.preset_hour;
  assign cl_minute = (tif.preset_minute > 6'd59) ? 6'd59 : tif.preset_minute;
  assign cl_second = (tif.preset_second > 6'd59) ? 6'd59 : tif.preset_second;
  assign cl_m_sec  = (tif.preset_m_sec  > 7'd99) ? 7'd99 : tif.preset_m_sec;

  // Borrow chain; only evaluated when time is nonzero, so hour never underflows.
  always_comb begin
    dec_m_sec  = m_sec_q - 7'd1;
    dec_second = second_q;
    dec_minute = minute_q;
    dec_hour   = hour_q;
    if (m_sec_q == 7'd0) begin
      dec_m_sec = 7'd99;
      if (second_q == 6'd0) begin
        dec_second = 6'd59;
        if (minute_q == 6'd0) begin
          dec_minute = 6'd59;
          dec_hour   = hour_q - 6'd1;
        end else begin
          dec_minute = minute_q - 6'd1;
        end
      end else begin
        dec_second = second_q - 6'd1;
      end
    end
  end

  assign dec_zero = (dec_hour == 6'd0) && (dec_minute == 6'd0) &&
                    (dec_second == 6'd0) && (dec_m_sec == 7'd0);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    hour_d   = hour_q;
    minute_d = minute_q;
    second_d = second_q;
    m_sec_d  = m_sec_q;
    pulse_d  = 1'b0;
    if (tif.load) begin
      state_d  = IDLE;
      presc_d  = '0;
      hour_d   = cl_hour;
      minute_d = cl_minute;
      second_d = cl_second;
      m_sec_d  = cl_m_sec;
    end else begin
      case (state_q)
        IDLE: begin
          if (tif.run && !time_zero) state_d = RUN;
        end
        RUN: begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          // A tick coinciding with run falling is still applied.
          if (tick) begin
            hour_d   = dec_hour;
            minute_d = dec_minute;
            second_d = dec_second;
            m_sec_d  = dec_m_sec;
          end
          if (tick && dec_zero) begin
            state_d = EXPIRED;
            presc_d = '0;
            pulse_d = 1'b1;
          end else if (!tif.run) begin
            state_d = IDLE;
          end
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      hour_q   <= 6'd0;
      minute_q <= 6'd0;
      second_q <= 6'd0;
      m_sec_q  <= 7'd0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      hour_q   <= hour_d;
      minute_q <= minute_d;
      second_q <= second_d;
      m_sec_q  <= m_sec_d;
      pulse_q  <= pulse_d;
    end
  end

  assign tif.hour         = hour_q;
  assign tif.minute       = minute_q;
  assign tif.second       = second_q;
  assign tif.m_sec        = m_sec_q;
  assign tif.running      = (state_q == RUN);
  assign tif.done         = (state_q == EXPIRED);
  assign tif.expire_pulse = pulse_q;
  assign tif.state_dbg    = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer at DIV=10: a total-hundredths model checked every cycle
// plus directed literal expectations.
module tb_countdown_timer;

  localparam int DIV = 10;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  countdown_timer_if tif();

  countdown_timer #(.CLOCK_HZ(1000), .TICK_HZ(100)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .tif     (tif)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int pulse_seen = 0;

  // ---------------- behavioural model ----------------
  // Time kept as total hundredths; mode 0 = idle, 1 = counting, 2 = expired.
  int m_total = 0;
  int m_cnt   = 0;
  int m_mode  = 0;
  bit m_pulse = 1'b0;

  function automatic int preset_total(int h, int m, int s, int ms);
    int hh, mm, ss, cc;
    hh = (h > 23) ? 23 : h;
    mm = (m > 59) ? 59 : m;
    ss = (s > 59) ? 59 : s;
    cc = (ms > 99) ? 99 : ms;
    return hh * 360000 + mm * 6000 + ss * 100 + cc;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_total = 0; m_cnt = 0; m_mode = 0; m_pulse = 1'b0;
    end else begin
      m_pulse = 1'b0;
      if (tif.load) begin
        m_total = preset_total(int'(tif.preset_hour), int'(tif.preset_minute),
                               int'(tif.preset_second), int'(tif.preset_m_sec));
        m_mode = 0;
        m_cnt  = 0;
      end else if (m_mode == 0) begin
        if (tif.run && m_total != 0) m_mode = 1;
      end else if (m_mode == 1) begin
        if (m_cnt == DIV - 1) begin
          m_cnt   = 0;
          m_total = m_total - 1;
          if (m_total == 0) begin
            m_mode  = 2;
            m_pulse = 1'b1;
          end
        end else begin
          m_cnt = m_cnt + 1;
        end
        if (m_mode == 1 && !tif.run) m_mode = 0;
      end
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge clock) begin
    logic [30:0] got, exp;
    if (chk_en) begin
      exp = {6'(m_total / 360000), 6'((m_total / 6000) % 60), 6'((m_total / 100) % 60),
             7'(m_total % 100), (m_mode == 1), (m_mode == 2), m_pulse, 3'b000};
      got = {tif.hour, tif.minute, tif.second, tif.m_sec,
             tif.running, tif.done, tif.expire_pulse, 3'b000};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model_cycle t=%0t got %0d:%0d:%0d.%0d r%0b d%0b p%0b exp %0d:%0d:%0d.%0d r%0b d%0b p%0b",
                 $time, got[30:25], got[24:19], got[18:13], got[12:6], got[5], got[4], got[3],
                 exp[30:25], exp[24:19], exp[18:13], exp[12:6], exp[5], exp[4], exp[3]);
      end
      if (tif.expire_pulse) pulse_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_load(input int h, input int m, input int s, input int ms);
    tif.preset_hour   = 6'(h);
    tif.preset_minute = 6'(m);
    tif.preset_second = 6'(s);
    tif.preset_m_sec  = 7'(ms);
    tif.load = 1'b1;
    @(negedge clock);
    tif.load = 1'b0;
  endtask

  task automatic check_lit(input string name, input int h, input int m, input int s,
                           input int ms, input bit r, input bit d, input bit p);
    checks++;
    if (tif.hour !== 6'(h) || tif.minute !== 6'(m) || tif.second !== 6'(s) ||
        tif.m_sec !== 7'(ms) || tif.running !== r || tif.done !== d || tif.expire_pulse !== p) begin
      errors++;
      $display("FAIL %s got %0d:%0d:%0d.%0d r%0b d%0b p%0b exp %0d:%0d:%0d.%0d r%0b d%0b p%0b",
               name, tif.hour, tif.minute, tif.second, tif.m_sec, tif.running, tif.done,
               tif.expire_pulse, h, m, s, ms, r, d, p);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    tif.run = 1'b0; tif.load = 1'b0;
    tif.preset_hour = '0; tif.preset_minute = '0; tif.preset_second = '0; tif.preset_m_sec = '0;
    run_n(2);
    check_lit("reset", 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Basic countdown 0:00:01.05 to expiry
    do_load(0, 0, 1, 5);
    check_lit("load_1_05", 0, 0, 1, 5, 0, 0, 0);
    tif.run = 1'b1;
    run_n(51);
    check_lit("tick5", 0, 0, 1, 0, 1, 0, 0);
    run_n(10);
    check_lit("tick6", 0, 0, 0, 99, 1, 0, 0);
    pulse_seen = 0;
    run_n(990);
    check_lit("tick105", 0, 0, 0, 0, 0, 1, 1);
    run_n(1);
    check_lit("expired_hold", 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      tif.run = ~tif.run;
      run_n(3);
    end
    check_lit("expired_run_toggle", 0, 0, 0, 0, 0, 1, 0);
    check_int("expire_pulse_count", pulse_seen, 1);

    // Borrow chain and non-borrowing fields
    tif.run = 1'b0;
    do_load(1, 0, 0, 0);
    tif.run = 1'b1;
    run_n(11);
    check_lit("borrow_chain", 0, 59, 59, 99, 1, 0, 0);
    tif.run = 1'b0;
    do_load(0, 5, 30, 20);
    tif.run = 1'b1;
    run_n(11);
    check_lit("no_borrow", 0, 5, 30, 19, 1, 0, 0);
    tif.run = 1'b0;
    do_load(0, 5, 0, 0);
    tif.run = 1'b1;
    run_n(11);
    check_lit("minute_borrow", 0, 4, 59, 99, 1, 0, 0);

    // Pause / resume keeps the partial tick
    tif.run = 1'b0;
    do_load(0, 0, 0, 50);
    tif.run = 1'b1;
    run_n(35);
    check_lit("pause_start", 0, 0, 0, 47, 1, 0, 0);
    tif.run = 1'b0;
    run_n(200);
    check_lit("pause_hold", 0, 0, 0, 47, 0, 0, 0);
    tif.run = 1'b1;
    run_n(5);
    check_lit("resume_pre", 0, 0, 0, 47, 1, 0, 0);
    run_n(1);
    check_lit("resume_tick", 0, 0, 0, 46, 1, 0, 0);

    // Clamp
    tif.run = 1'b0;
    do_load(40, 63, 60, 120);
    check_lit("clamp", 23, 59, 59, 99, 0, 0, 0);

    // Load in the tick cycle discards the tick and restarts the prescaler
    do_load(0, 0, 0, 30);
    tif.run = 1'b1;
    run_n(10);
    do_load(0, 0, 2, 0);
    check_lit("load_in_tick", 0, 0, 2, 0, 0, 0, 0);
    run_n(10);
    check_lit("presc_restart_pre", 0, 0, 2, 0, 1, 0, 0);
    run_n(1);
    check_lit("presc_restart_tick", 0, 0, 1, 99, 1, 0, 0);

    // run with zero time in idle
    tif.run = 1'b0;
    do_load(0, 0, 0, 0);
    pulse_seen = 0;
    tif.run = 1'b1;
    run_n(20);
    check_lit("zero_idle", 0, 0, 0, 0, 0, 0, 0);
    check_int("zero_idle_no_pulse", pulse_seen, 0);

    // Asynchronous reset mid-run
    tif.run = 1'b0;
    do_load(0, 10, 0, 0);
    tif.run = 1'b1;
    run_n(30);
    check_lit("pre_reset", 0, 9, 59, 98, 1, 0, 0);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check_lit("async_reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    run_n(20);
    check_lit("post_reset_idle", 0, 0, 0, 0, 0, 0, 0);
    do_load(0, 0, 0, 5);
    run_n(1);
    check_lit("rearm", 0, 0, 0, 5, 1, 0, 0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
